ex_mem_pipe_reg: RTL and testbench

- EX/MEM pipeline register of the 5-stage MIPS core.
- Sits between the execute stage (ALU, branch-target adder) and the memory stage (data cache, branch resolution).
- Captures EX-stage datapath values and MEM/WB control bits on each rising clock edge while the memory system reports a hit.
- Holds its contents (stall) on a miss; supports synchronous reset and bubble insertion (flush).

---
 rtl/ex_mem_pipe_reg.sv | 84 ++++++++
 tb/tb_ex_mem_pipe_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg
//   EX/MEM pipeline register of the 5-stage MIPS core. Captures the execute
//   stage datapath values (branch target, ALU result, store data, destination
//   register) and the MEM/WB control bits on each rising clock edge.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   hit                 pipeline advance enable (1 = load, 0 = stall/hold)
//   flush               synchronous bubble insert (clears control outputs)
//   branch_target, alu_result, read_data_2, write_reg   EX datapath inputs
//   branch, zeroflag, mem_to_reg, reg_write, mem_read, mem_write   control inputs
//   *_out / zeroflagOut registered copies of the inputs above
//
// Advance protocol: there is no valid/ready pair here. 'hit' acts as the
// single advance strobe from the memory system. On an edge with hit=1 the
// register accepts whatever EX presents; with hit=0 it holds, and EX is
// expected to hold as well. Flush overrides hit, and reset overrides both.
module ex_mem_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hit,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     branch_target,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     read_data_2,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic                  branch,
  input  logic                  zeroflag,
  input  logic                  mem_to_reg,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_W-1:0]     branch_target_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     read_data_2_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic                  zeroflagOut,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  branch_out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_target_out <= '0;
      alu_result_out    <= '0;
      read_data_2_out   <= '0;
      write_reg_out     <= '0;
      branch_out        <= 1'b0;
      zeroflagOut       <= 1'b0;
      mem_to_reg_out    <= 1'b0;
      reg_write_out     <= 1'b0;
      mem_read_out      <= 1'b0;
      mem_write_out     <= 1'b0;
    end else if (flush) begin
      // Bubble: kill every side effect downstream, but leave the datapath
      // fields alone -- with all controls at 0 they are never consumed.
      branch_out        <= 1'b0;
      zeroflagOut       <= 1'b0;
      mem_to_reg_out    <= 1'b0;
      reg_write_out     <= 1'b0;
      mem_read_out      <= 1'b0;
      mem_write_out     <= 1'b0;
    end else if (hit) begin
      branch_target_out <= branch_target;
      alu_result_out    <= alu_result;
      read_data_2_out   <= read_data_2;
      write_reg_out     <= write_reg;
      branch_out        <= branch;
      zeroflagOut       <= zeroflag;
      mem_to_reg_out    <= mem_to_reg;
      reg_write_out     <= reg_write;
      mem_read_out      <= mem_read;
      mem_write_out     <= mem_write;
    end
    // hit=0 without flush: every flop keeps its value (stall).
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
module tb_ex_mem_pipe_reg;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int OUT_W = 3*DW + RW + 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, hit, flush;
  logic [DW-1:0] branch_target, alu_result, read_data_2;
  logic [RW-1:0] write_reg;
  logic          branch, zeroflag, mem_to_reg, reg_write, mem_read, mem_write;
  logic [DW-1:0] branch_target_out, alu_result_out, read_data_2_out;
  logic [RW-1:0] write_reg_out;
  logic          zeroflagOut, mem_to_reg_out, reg_write_out, mem_read_out;
  logic          mem_write_out, branch_out;

  ex_mem_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush),
    .branch_target(branch_target), .alu_result(alu_result),
    .read_data_2(read_data_2), .write_reg(write_reg),
    .branch(branch), .zeroflag(zeroflag), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch_target_out(branch_target_out), .alu_result_out(alu_result_out),
    .read_data_2_out(read_data_2_out), .write_reg_out(write_reg_out),
    .zeroflagOut(zeroflagOut), .mem_to_reg_out(mem_to_reg_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .branch_out(branch_out)
  );

  // Output view: {bt, alu, rd2, wr, branch, zero, m2r, rw, mr, mw}
  logic [OUT_W-1:0] dut_vec;
  assign dut_vec = {branch_target_out, alu_result_out, read_data_2_out, write_reg_out,
                    branch_out, zeroflagOut, mem_to_reg_out, reg_write_out,
                    mem_read_out, mem_write_out};

  function automatic logic [OUT_W-1:0] pack(input logic [DW-1:0] bt,
                                            input logic [DW-1:0] alu,
                                            input logic [DW-1:0] rd2,
                                            input logic [RW-1:0] wr,
                                            input logic [5:0] c);
    return {bt, alu, rd2, wr, c};
  endfunction

  // ---------------- reference model ----------------
  // The register's architectural content as one record, updated by the
  // priority rules reset > flush > hit > hold.
  typedef struct {
    logic [DW-1:0] bt, alu, rd2;
    logic [RW-1:0] wr;
    logic [5:0]    ctrl;
  } model_t;

  model_t model;
  bit     model_valid = 1'b0;

  function automatic model_t model_next(input model_t m, input logic r, input logic h,
                                        input logic f, input logic [DW-1:0] bt,
                                        input logic [DW-1:0] alu, input logic [DW-1:0] rd2,
                                        input logic [RW-1:0] wr, input logic [5:0] c);
    model_t n = m;
    if (!r) begin
      n.bt = '0; n.alu = '0; n.rd2 = '0; n.wr = '0; n.ctrl = '0;
    end else if (f) begin
      n.ctrl = '0;
    end else if (h) begin
      n.bt = bt; n.alu = alu; n.rd2 = rd2; n.wr = wr; n.ctrl = c;
    end
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs mid-cycle, confirm the outputs did not react before the edge,
  // then clock once and compare against the model.
  task automatic step(input string name, input logic r, input logic h, input logic f,
                      input logic [DW-1:0] bt, input logic [DW-1:0] alu,
                      input logic [DW-1:0] rd2, input logic [RW-1:0] wr,
                      input logic [5:0] c, output logic [OUT_W-1:0] act);
    logic [OUT_W-1:0] e;
    rst_n = r; hit = h; flush = f;
    branch_target = bt; alu_result = alu; read_data_2 = rd2; write_reg = wr;
    {branch, zeroflag, mem_to_reg, reg_write, mem_read, mem_write} = c;
    #1;
    if (model_valid)
      check({name, "/no_comb"}, dut_vec, pack(model.bt, model.alu, model.rd2, model.wr, model.ctrl));
    model = model_next(model, r, h, f, bt, alu, rd2, wr, c);
    model_valid = 1'b1;
    exp_q.push_back(pack(model.bt, model.alu, model.rd2, model.wr, model.ctrl));
    @(posedge clk);
    #1;
    act = dut_vec;
    e = exp_q.pop_front();
    check({name, "/model"}, act, e);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string            name;
    logic             r, h, f;
    logic [DW-1:0]    bt, alu, rd2;
    logic [RW-1:0]    wr;
    logic [5:0]       c;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] act;
    logic [OUT_W-1:0] zero_vec;
    zero_vec = '0;

    rst_n = 1'b0; hit = 1'b0; flush = 1'b0;
    branch_target = '0; alu_result = '0; read_data_2 = '0; write_reg = '0;
    {branch, zeroflag, mem_to_reg, reg_write, mem_read, mem_write} = '0;

    //          name         r     h     f     bt            alu           rd2           wr     ctrl       expected
    tbl[0]  = '{"reset0",    1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hCAFEF00D, 5'd31, 6'b111111, zero_vec};
    tbl[1]  = '{"reset1",    1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hCAFEF00D, 5'd31, 6'b111111, zero_vec};
    tbl[2]  = '{"stall0",    1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 32'd1, 5'd0, 6'b101010, zero_vec};
    tbl[3]  = '{"stall1",    1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 32'd1, 5'd0, 6'b101010, zero_vec};
    tbl[4]  = '{"load",      1'b1, 1'b1, 1'b0, 32'd1, 32'd0, 32'd1, 5'd0, 6'b101010,
                pack(32'd1, 32'd0, 32'd1, 5'd0, 6'b101010)};
    tbl[5]  = '{"miss0",     1'b1, 1'b0, 1'b0, 32'd1, 32'h12345678, 32'd1, 5'd7, 6'b101110,
                pack(32'd1, 32'd0, 32'd1, 5'd0, 6'b101010)};
    tbl[6]  = '{"miss1",     1'b1, 1'b0, 1'b0, 32'd1, 32'h12345678, 32'd1, 5'd7, 6'b101110,
                pack(32'd1, 32'd0, 32'd1, 5'd0, 6'b101010)};
    tbl[7]  = '{"miss2",     1'b1, 1'b0, 1'b0, 32'd1, 32'h12345678, 32'd1, 5'd7, 6'b101110,
                pack(32'd1, 32'd0, 32'd1, 5'd0, 6'b101010)};
    tbl[8]  = '{"hit_after", 1'b1, 1'b1, 1'b0, 32'd1, 32'h12345678, 32'd1, 5'd7, 6'b101110,
                pack(32'd1, 32'h12345678, 32'd1, 5'd7, 6'b101110)};
    tbl[9]  = '{"flush_hit", 1'b1, 1'b1, 1'b1, 32'h0BADC0DE, 32'hAAAAAAAA, 32'h55555555, 5'd3, 6'b111111,
                pack(32'd1, 32'h12345678, 32'd1, 5'd7, 6'b000000)};
    tbl[10] = '{"flush_miss",1'b1, 1'b0, 1'b1, 32'h0BADC0DE, 32'hAAAAAAAA, 32'h55555555, 5'd3, 6'b111111,
                pack(32'd1, 32'h12345678, 32'd1, 5'd7, 6'b000000)};
    tbl[11] = '{"reload",    1'b1, 1'b1, 1'b0, 32'd2, 32'h55, 32'd3, 5'd9, 6'b010101,
                pack(32'd2, 32'h55, 32'd3, 5'd9, 6'b010101)};
    tbl[12] = '{"reset_hit", 1'b0, 1'b1, 1'b0, 32'd4, 32'h66, 32'd5, 5'd11, 6'b110011, zero_vec};

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].name, tbl[i].r, tbl[i].h, tbl[i].f, tbl[i].bt, tbl[i].alu,
           tbl[i].rd2, tbl[i].wr, tbl[i].c, act);
      check({tbl[i].name, "/table"}, act, tbl[i].exp);
    end

    // Pipelined stream: alu_result_out trails alu_result by exactly one edge.
    for (int i = 1; i <= 10; i++) begin
      logic [DW-1:0] v;
      v = DW'(i);
      step("stream", 1'b1, 1'b1, 1'b0, $urandom, v, $urandom, RW'($urandom),
           6'($urandom), act);
      tests++;
      if (alu_result_out !== v) begin
        fails++;
        $display("FAIL stream_alu: got %h expected %h", alu_result_out, v);
      end
    end
    step("stream_rst", 1'b0, 1'b1, 1'b0, 32'd11, 32'd11, 32'd11, 5'd11, 6'b111111, act);
    check("stream_rst/zero", act, zero_vec);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, h, f;
      r = ($urandom_range(0, 19) != 0);
      f = ($urandom_range(0, 7) == 0);
      h = $urandom_range(0, 1);
      step("random", r, h, f, $urandom, $urandom, $urandom, RW'($urandom),
           6'($urandom), act);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
